dts_align_ctrl: RTL and testbench
=================================

Name: dts_align_ctrl

Overview:
- Control-side initiator for the DTS offset FIFOs. Watches the `sync` outputs of N per-stream offset blocks, measures relative sync arrival, and issues `advance`/`delay` pulses until every stream's sync lands in the same cycle.
- Sits in the output clock domain, after the offset FIFOs and ahead of the multi-stream DTS consumer.
- Reports alignment status and keeps monitoring once locked.

Parameters:
- N_STREAMS, 4, number of DTS streams controlled.
- MAX_SKEW, 31, largest measurable sync spread in cycles; the measurement window is MAX_SKEW+1 cycles.
- PULSE_LEN, 4, cycles each advance/delay pulse is held high, followed by PULSE_LEN cycles low. Must be ≥2 so the pulse survives the crossing into clk_in.
- SETTLE_CYCLES, 256, wait after a correction burst before re-measuring.
- TIMEOUT, 65535, cycles allowed for the first sync edge in MEASURE.
- MAX_ITER, 64, correction iterations allowed before failure.

Ports:
- clk  in  1  output-domain clock shared with the offsetters' read side.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; high runs alignment, low returns to IDLE.
- sync_in  in  N_STREAMS  per-stream dout_sync; rising edge = frame marker.
- advance  out  N_STREAMS  per-stream advance pulses.
- delay  out  N_STREAMS  per-stream delay pulses.
- aligned  out  1  high only in LOCKED.
- busy  out  1  high in MEASURE/CORRECT/SETTLE.
- fail  out  1  sticky until enable low or reset.
- fail_code  out  2  1 = no sync (timeout), 2 = skew > MAX_SKEW, 3 = MAX_ITER exceeded.
- skew  out  $clog2(MAX_SKEW+1)  last measured max−min arrival.
- realign_count  out  16  count of LOCKED→MEASURE exits; saturates at 0xFFFF.

Behaviour:
- Reset: all outputs 0, state IDLE, edge-detect registers 0. Every output is registered.
- Edge detect: sync_in is registered each cycle. edge_i = sync_in[i] & ~sync_q[i].
- IDLE:
  - enable=1 → MEASURE, iteration counter cleared.
  - enable=0 in any state → IDLE next cycle. Pulses in progress are truncated to 0 immediately; fail and fail_code are cleared.
- MEASURE:
  - Wait for the first edge on any stream; if none within TIMEOUT cycles → FAIL, code 1.
  - The first edge starts the window counter at 0. Each stream latches its counter value t_i at its first edge; edges in the same cycle share the same t.
  - Window closes after MAX_SKEW+1 cycles. Any stream without an edge → FAIL, code 2.
  - Otherwise skew = max(t) − min(t).
  - skew=0:
    - If the previous measurement also gave 0 → LOCKED.
    - Else → SETTLE without issuing pulses (double confirmation).
  - skew≠0 → CORRECT.
- CORRECT:
  - Increment iterations; if iterations > MAX_ITER → FAIL, code 3.
  - Per stream, issue exactly one pulse when its target differs from its arrival. Base target is latest: delay[i] if t_i < max(t).
  - All stream pulses fire in the same cycle, high PULSE_LEN then low PULSE_LEN, then → SETTLE.
  - Each pulse moves its stream one step, so convergence takes at most skew iterations.
- SETTLE: count SETTLE_CYCLES, then → MEASURE.
- LOCKED:
  - aligned=1. Each frame, if all edges fall in the same cycle, stay.
  - If an edge on some streams is not matched on all within MAX_SKEW+1 cycles: aligned drops the next cycle, realign_count increments, iterations clear, → MEASURE.
  - The frame that triggered the exit is not reused for measurement.
- FAIL: fail=1, aligned=0, no pulses; stays until enable low or reset.
- Reset mid-pulse: advance/delay go to 0 asynchronously.

Optional Feature:
- Macro: DTS_ALIGN_ADVANCE_EN.
- Defined: the target is stream 0's arrival t_0.
  - Streams with t_i > t_0 get advance[i].
  - Streams with t_i < t_0 get delay[i].
  - Stream 0 never pulses.
- Undefined: the target is the latest arrival, only delay pulses are issued, and advance is tied to 0.

Test Plan:
- All 4 syncs coincident every 1000 cycles, enable=1 → no pulses; aligned=1 after the second zero-skew measurement; skew=0.
- Stream 2 sync 3 cycles earlier than the others → three iterations, each with one PULSE_LEN=4 pulse on delay[2] only; then aligned=1, realign_count=0.
- Stream 1 sync 40 cycles late (MAX_SKEW=31) → fail=1, fail_code=2, no pulses.
- sync_in held 0 with TIMEOUT=100 → fail=1, fail_code=1 at cycle 100 after entering MEASURE.
- From LOCKED, shift stream 3 by +1 cycle → aligned=0, realign_count=1, one correction, relock. Deassert rst_n during the pulse → delay/advance=0 immediately, aligned=0.
- With DTS_ALIGN_ADVANCE_EN, t = {0, +2, −1, 0} relative to stream 0 → advance[1] and delay[2] pulse in iteration 1; advance[1] only in iteration 2; then lock.

Source files
------------

// File: rtl/dts_align_ctrl.sv
// Sync-alignment controller for N DTS offset FIFOs: measures sync arrival spread and
// pulses delay (or advance, when DTS_ALIGN_ADVANCE_EN is defined) until all streams coincide.
module dts_align_ctrl #(
    parameter int N_STREAMS     = 4,
    parameter int MAX_SKEW      = 31,
    parameter int PULSE_LEN     = 4,
    parameter int SETTLE_CYCLES = 256,
    parameter int TIMEOUT       = 65535,
    parameter int MAX_ITER      = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic [N_STREAMS-1:0]            sync_in,
    output logic [N_STREAMS-1:0]            advance,
    output logic [N_STREAMS-1:0]            delay,
    output logic                            aligned,
    output logic                            busy,
    output logic                            fail,
    output logic [1:0]                      fail_code,
    output logic [$clog2(MAX_SKEW+1)-1:0]   skew,
    output logic [15:0]                     realign_count
);

    localparam int SW = $clog2(MAX_SKEW + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = $clog2(MAX_ITER + 1);
    localparam int PW = $clog2(2 * PULSE_LEN);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [SW-1:0] WIN_LAST  = SW'(MAX_SKEW);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] ITER_MAX  = IW'(MAX_ITER);
    localparam logic [PW-1:0] PC_LAST   = PW'(2 * PULSE_LEN - 1);
    localparam logic [PW-1:0] PULSE_END = PW'(PULSE_LEN);
    localparam logic [CW-1:0] SC_LAST   = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_MEASURE, S_CORRECT, S_SETTLE, S_LOCKED, S_FAIL
    } state_t;

    state_t               state_q, state_d;
    logic [N_STREAMS-1:0] sync_q;
    logic [N_STREAMS-1:0] sync_rise;
    logic                 started_q, started_d;
    logic [N_STREAMS-1:0] seen_q, seen_d;
    logic [SW-1:0]        win_q, win_d;
    logic [SW-1:0]        win_cur;
    logic [TW-1:0]        to_q, to_d;
    logic [SW-1:0]        t_q [N_STREAMS];
    logic [SW-1:0]        t_d [N_STREAMS];
    logic [SW-1:0]        t_now [N_STREAMS];
    logic [SW-1:0]        t_max, t_min, skew_now;
    logic [IW-1:0]        iter_q, iter_d;
    logic                 prev_zero_q, prev_zero_d;
    logic [PW-1:0]        pc_q, pc_d;
    logic [CW-1:0]        sc_q, sc_d;
    logic [1:0]           fc_q, fc_d;
    logic [SW-1:0]        skew_q, skew_d;
    logic [15:0]          realign_q, realign_d;
    logic [N_STREAMS-1:0] dly_mask_q, dly_mask_d, dly_cand;
    logic [N_STREAMS-1:0] delay_q, delay_d;
    logic                 aligned_q, aligned_d;
    logic                 busy_q, busy_d;
    logic                 fail_q, fail_d;
    logic [1:0]           fail_code_q, fail_code_d;
`ifdef DTS_ALIGN_ADVANCE_EN
    logic [N_STREAMS-1:0] adv_mask_q, adv_mask_d, adv_cand;
    logic [N_STREAMS-1:0] advance_q, advance_d;
`endif

    // Edges landing in the window's first cycle share t=0, later ones take the running count.
    assign win_cur = started_q ? win_q : '0;

    genvar gi;
    generate
        for (gi = 0; gi < N_STREAMS; gi++) begin : g_stream
            assign sync_rise[gi] = sync_in[gi] & ~sync_q[gi];
            assign t_now[gi]     = (sync_rise[gi] && !seen_q[gi]) ? win_cur : t_q[gi];
`ifdef DTS_ALIGN_ADVANCE_EN
            if (gi == 0) begin : g_ref
                assign adv_cand[gi] = 1'b0;
                assign dly_cand[gi] = 1'b0;
            end else begin : g_follow
                assign adv_cand[gi] = t_now[gi] > t_now[0];
                assign dly_cand[gi] = t_now[gi] < t_now[0];
            end
`else
            assign dly_cand[gi] = t_now[gi] < t_max;
`endif
        end
    endgenerate

    always_comb begin
        t_max = '0;
        t_min = '1;
        for (int i = 0; i < N_STREAMS; i++) begin
            if (t_now[i] > t_max) t_max = t_now[i];
            if (t_now[i] < t_min) t_min = t_now[i];
        end
        skew_now = t_max - t_min;
    end

    // State register, including the registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sync_q      <= '0;
            started_q   <= 1'b0;
            seen_q      <= '0;
            win_q       <= '0;
            to_q        <= '0;
            for (int i = 0; i < N_STREAMS; i++) t_q[i] <= '0;
            iter_q      <= '0;
            prev_zero_q <= 1'b0;
            pc_q        <= '0;
            sc_q        <= '0;
            fc_q        <= '0;
            skew_q      <= '0;
            realign_q   <= '0;
            dly_mask_q  <= '0;
            delay_q     <= '0;
            aligned_q   <= 1'b0;
            busy_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_code_q <= '0;
`ifdef DTS_ALIGN_ADVANCE_EN
            adv_mask_q  <= '0;
            advance_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_in;
            started_q   <= started_d;
            seen_q      <= seen_d;
            win_q       <= win_d;
            to_q        <= to_d;
            for (int i = 0; i < N_STREAMS; i++) t_q[i] <= t_d[i];
            iter_q      <= iter_d;
            prev_zero_q <= prev_zero_d;
            pc_q        <= pc_d;
            sc_q        <= sc_d;
            fc_q        <= fc_d;
            skew_q      <= skew_d;
            realign_q   <= realign_d;
            dly_mask_q  <= dly_mask_d;
            delay_q     <= delay_d;
            aligned_q   <= aligned_d;
            busy_q      <= busy_d;
            fail_q      <= fail_d;
            fail_code_q <= fail_code_d;
`ifdef DTS_ALIGN_ADVANCE_EN
            adv_mask_q  <= adv_mask_d;
            advance_q   <= advance_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        started_d   = started_q;
        seen_d      = seen_q;
        win_d       = win_q;
        to_d        = to_q;
        for (int i = 0; i < N_STREAMS; i++) t_d[i] = t_q[i];
        iter_d      = iter_q;
        prev_zero_d = prev_zero_q;
        pc_d        = pc_q;
        sc_d        = sc_q;
        fc_d        = fc_q;
        skew_d      = skew_q;
        realign_d   = realign_q;
        dly_mask_d  = dly_mask_q;
`ifdef DTS_ALIGN_ADVANCE_EN
        adv_mask_d  = adv_mask_q;
`endif
        if (!enable) begin
            state_d = S_IDLE;
            fc_d    = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d     = S_MEASURE;
                    iter_d      = '0;
                    prev_zero_d = 1'b0;
                end
                S_MEASURE: begin
                    for (int i = 0; i < N_STREAMS; i++) t_d[i] = t_now[i];
                    seen_d = seen_q | sync_rise;
                    if (!started_q) begin
                        if (|sync_rise) begin
                            started_d = 1'b1;
                            win_d     = SW'(1);
                        end else if (to_q == TO_LAST) begin
                            state_d = S_FAIL;
                            fc_d    = 2'd1;
                        end else begin
                            to_d = to_q + 1'b1;
                        end
                    end else begin
                        win_d = win_q + 1'b1;
                        if (win_q == WIN_LAST) begin
                            if (!(&seen_d)) begin
                                state_d = S_FAIL;
                                fc_d    = 2'd2;
                            end else if (skew_now == '0) begin
                                skew_d = '0;
                                if (prev_zero_q) begin
                                    state_d = S_LOCKED;
                                end else begin
                                    state_d     = S_SETTLE;
                                    prev_zero_d = 1'b1;
                                end
                            end else begin
                                skew_d      = skew_now;
                                prev_zero_d = 1'b0;
                                if (iter_q >= ITER_MAX) begin
                                    state_d = S_FAIL;
                                    fc_d    = 2'd3;
                                end else begin
                                    state_d    = S_CORRECT;
                                    iter_d     = iter_q + 1'b1;
                                    dly_mask_d = dly_cand;
`ifdef DTS_ALIGN_ADVANCE_EN
                                    adv_mask_d = adv_cand;
`endif
                                end
                            end
                        end
                    end
                end
                S_CORRECT: begin
                    pc_d = pc_q + 1'b1;
                    if (pc_q == PC_LAST) state_d = S_SETTLE;
                end
                S_SETTLE: begin
                    sc_d = sc_q + 1'b1;
                    if (sc_q == SC_LAST) state_d = S_MEASURE;
                end
                S_LOCKED: begin
                    // A partial frame opens a window; leave once it is fully consumed.
                    if (!started_q) begin
                        if (|sync_rise && !(&sync_rise)) begin
                            started_d = 1'b1;
                            seen_d    = sync_rise;
                            win_d     = SW'(1);
                        end
                    end else begin
                        seen_d = seen_q | sync_rise;
                        win_d  = win_q + 1'b1;
                        if ((&seen_d) || (win_q == WIN_LAST)) begin
                            state_d     = S_MEASURE;
                            iter_d      = '0;
                            prev_zero_d = 1'b0;
                            if (realign_q != 16'hFFFF) realign_d = realign_q + 16'd1;
                        end
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        if (state_d != state_q) begin
            started_d = 1'b0;
            seen_d    = '0;
            win_d     = '0;
            to_d      = '0;
            pc_d      = '0;
            sc_d      = '0;
        end
    end

    // Output logic, looking at the next state so every output lands with its state.
    always_comb begin
        aligned_d   = (state_d == S_LOCKED);
        busy_d      = (state_d == S_MEASURE) || (state_d == S_CORRECT) || (state_d == S_SETTLE);
        fail_d      = (state_d == S_FAIL);
        fail_code_d = (state_d == S_FAIL) ? fc_d : 2'd0;
        delay_d     = ((state_d == S_CORRECT) && (pc_d < PULSE_END)) ? dly_mask_d : '0;
`ifdef DTS_ALIGN_ADVANCE_EN
        advance_d   = ((state_d == S_CORRECT) && (pc_d < PULSE_END)) ? adv_mask_d : '0;
`endif
    end

`ifdef DTS_ALIGN_ADVANCE_EN
    assign advance = advance_q;
`else
    assign advance = '0;
`endif
    assign delay         = delay_q;
    assign aligned       = aligned_q;
    assign busy          = busy_q;
    assign fail          = fail_q;
    assign fail_code     = fail_code_q;
    assign skew          = skew_q;
    assign realign_count = realign_q;

endmodule

// File: tb/tb_dts_align_ctrl.sv
// Directed bench for dts_align_ctrl: a frame generator models the offset FIFOs, shifting
// each stream one cycle per delay (+1) or advance (-1) pulse.
`define CHECK(TAG, OBS, EXP) begin tests++; assert ((OBS) === (EXP)) else begin failed++; $error("FAIL %s: observed %0d expected %0d", TAG, (OBS), (EXP)); end end

module tb_dts_align_ctrl;

    localparam int N      = 4;
    localparam int PERIOD = 80;
    localparam int PLEN   = 4;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic [N-1:0] sync_in;
    logic [N-1:0] advance;
    logic [N-1:0] delay;
    logic         aligned;
    logic         busy;
    logic         fail;
    logic [1:0]   fail_code;
    logic [4:0]   skew;
    logic [15:0]  realign_count;

    int tests;
    int failed;

    int fc;
    int base_off [N];
    int adj [N];
    bit gen_en;
    bit adj_clr;
    int dly_cnt [N];
    int adv_cnt [N];
    int run_d [N];
    int run_a [N];
    int bad_w;
    int snap_d [N];
    int snap_a [N];
    int cyc;

    dts_align_ctrl #(
        .N_STREAMS     (N),
        .MAX_SKEW      (31),
        .PULSE_LEN     (PLEN),
        .SETTLE_CYCLES (16),
        .TIMEOUT       (100),
        .MAX_ITER      (64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .sync_in       (sync_in),
        .advance       (advance),
        .delay         (delay),
        .aligned       (aligned),
        .busy          (busy),
        .fail          (fail),
        .fail_code     (fail_code),
        .skew          (skew),
        .realign_count (realign_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame generator, offset-FIFO model and pulse monitor.
    initial begin
        logic [N-1:0] s;
        logic [N-1:0] dly_prev;
        logic [N-1:0] adv_prev;
        fc       = 0;
        dly_prev = '0;
        adv_prev = '0;
        bad_w    = 0;
        sync_in  = '0;
        for (int i = 0; i < N; i++) begin
            adj[i] = 0; dly_cnt[i] = 0; adv_cnt[i] = 0; run_d[i] = 0; run_a[i] = 0;
        end
        forever begin
            @(negedge clk);
            fc = (fc == PERIOD - 1) ? 0 : fc + 1;
            for (int i = 0; i < N; i++) begin
                if (delay[i] && !dly_prev[i]) dly_cnt[i]++;
                if (advance[i] && !adv_prev[i]) adv_cnt[i]++;
                if (adj_clr) adj[i] = 0;
                else begin
                    if (delay[i] && !dly_prev[i]) adj[i]++;
                    if (advance[i] && !adv_prev[i]) adj[i]--;
                end
                if (delay[i]) run_d[i]++;
                else if (run_d[i] != 0) begin
                    if (run_d[i] != PLEN) bad_w++;
                    run_d[i] = 0;
                end
                if (advance[i]) run_a[i]++;
                else if (run_a[i] != 0) begin
                    if (run_a[i] != PLEN) bad_w++;
                    run_a[i] = 0;
                end
                s[i] = gen_en && (fc == 20 + base_off[i] + adj[i]);
            end
            dly_prev = delay;
            adv_prev = advance;
            sync_in  = s;
        end
    end

    function automatic bit cond(input int which);
        case (which)
            0: cond = (aligned === 1'b1);
            1: cond = (aligned === 1'b0);
            2: cond = (fail === 1'b1);
            3: cond = ((delay | advance) !== '0);
            default: cond = (busy === 1'b1);
        endcase
    endfunction

    task automatic wait_sig(input int which, input int lim, output int cycles);
        cycles = -1;
        for (int k = 1; k <= lim && cycles < 0; k++) begin
            @(negedge clk);
            if (cond(which)) cycles = k;
        end
    endtask

    task automatic wait_phase0();
        for (int k = 0; k < 2 * PERIOD && fc != 0; k++) @(negedge clk);
    endtask

    task automatic restart(input int o0, input int o1, input int o2, input int o3);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        base_off[0] = o0; base_off[1] = o1; base_off[2] = o2; base_off[3] = o3;
        adj_clr = 1'b1;
        @(negedge clk);
        adj_clr = 1'b0;
        for (int i = 0; i < N; i++) begin
            snap_d[i] = dly_cnt[i];
            snap_a[i] = adv_cnt[i];
        end
        wait_phase0();
        enable = 1'b1;
    endtask

    function automatic int dsum();
        dsum = 0;
        for (int i = 0; i < N; i++) dsum += (dly_cnt[i] - snap_d[i]) + (adv_cnt[i] - snap_a[i]);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests   = 0;
        failed  = 0;
        rst_n   = 1'b0;
        enable  = 1'b0;
        gen_en  = 1'b1;
        adj_clr = 1'b0;
        for (int i = 0; i < N; i++) base_off[i] = 0;
        repeat (3) @(negedge clk);
        `CHECK("reset_advance", advance, 4'b0000)
        `CHECK("reset_delay", delay, 4'b0000)
        `CHECK("reset_aligned", aligned, 1'b0)
        `CHECK("reset_busy", busy, 1'b0)
        `CHECK("reset_fail", fail, 1'b0)
        `CHECK("reset_fail_code", fail_code, 2'd0)
        `CHECK("reset_skew", skew, 5'd0)
        `CHECK("reset_realign", realign_count, 16'd0)
        rst_n = 1'b1;
        @(negedge clk);

        // All streams coincident: lock after the second zero-skew frame, no pulses.
        restart(0, 0, 0, 0);
        repeat (90) @(negedge clk);
        `CHECK("t1_busy_frame1", busy, 1'b1)
        `CHECK("t1_not_aligned_frame1", aligned, 1'b0)
        wait_sig(0, 200, cyc);
        `CHECK("t1_lock_reached", (cyc > 0), 1'b1)
        `CHECK("t1_skew", skew, 5'd0)
        repeat (3 * PERIOD) @(negedge clk);
        `CHECK("t1_stays_aligned", aligned, 1'b1)
        `CHECK("t1_realign", realign_count, 16'd0)
        `CHECK("t1_no_pulses", dsum(), 0)
        $display("[TB] coincident: lock after %0d cycles, skew=%0d", cyc, skew);

        // Stream 2 three cycles early: three single delay[2] corrections.
        restart(0, 0, -3, 0);
        wait_sig(3, 300, cyc);
        `CHECK("t2_pulse_seen", (cyc > 0), 1'b1)
        `CHECK("t2_first_delay", delay, 4'b0100)
        `CHECK("t2_first_advance", advance, 4'b0000)
        `CHECK("t2_first_skew", skew, 5'd3)
        wait_sig(0, 1500, cyc);
        `CHECK("t2_lock_reached", (cyc > 0), 1'b1)
        `CHECK("t2_delay2_count", dly_cnt[2] - snap_d[2], 3)
        `CHECK("t2_total_pulses", dsum(), 3)
        `CHECK("t2_realign", realign_count, 16'd0)
        `CHECK("t2_skew_locked", skew, 5'd0)
        `CHECK("t2_pulse_width", bad_w, 0)
        $display("[TB] early stream 2: delay[2] pulses=%0d", dly_cnt[2] - snap_d[2]);

        // Stream 1 forty cycles late: window overflow.
        restart(0, 40, 0, 0);
        wait_sig(2, 300, cyc);
        `CHECK("t3_fail_seen", (cyc > 0), 1'b1)
        `CHECK("t3_fail_code", fail_code, 2'd2)
        `CHECK("t3_no_pulses", dsum(), 0)
        `CHECK("t3_aligned", aligned, 1'b0)
        `CHECK("t3_busy", busy, 1'b0)
        $display("[TB] late stream 1: fail_code=%0d", fail_code);

        // No sync at all: timeout exactly TIMEOUT cycles after MEASURE entry.
        enable = 1'b0;
        repeat (2) @(negedge clk);
        `CHECK("t4_fail_cleared", fail, 1'b0)
        `CHECK("t4_code_cleared", fail_code, 2'd0)
        gen_en = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        wait_sig(4, 10, cyc);
        `CHECK("t4_busy_entry", cyc, 1)
        wait_sig(2, 200, cyc);
        `CHECK("t4_timeout_cycles", cyc, 100)
        `CHECK("t4_fail_code", fail_code, 2'd1)
        repeat (50) @(negedge clk);
        `CHECK("t4_fail_sticky", fail, 1'b1)
        $display("[TB] no sync: fail after %0d cycles, code=%0d", cyc, fail_code);
        gen_en = 1'b1;

`ifdef DTS_ALIGN_ADVANCE_EN
        // Offsets {0,+2,-1,0} against stream 0.
        restart(0, 2, -1, 0);
        wait_sig(3, 300, cyc);
        `CHECK("t6_iter1_advance", advance, 4'b0010)
        `CHECK("t6_iter1_delay", delay, 4'b0100)
        wait_sig(1, 0, cyc);
        repeat (2 * PLEN) @(negedge clk);
        wait_sig(3, 300, cyc);
        `CHECK("t6_iter2_advance", advance, 4'b0010)
        `CHECK("t6_iter2_delay", delay, 4'b0000)
        wait_sig(0, 1500, cyc);
        `CHECK("t6_lock_reached", (cyc > 0), 1'b1)
        `CHECK("t6_adv1_count", adv_cnt[1] - snap_a[1], 2)
        `CHECK("t6_total_pulses", dsum(), 3)
        $display("[TB] advance mode: advance[1] pulses=%0d", adv_cnt[1] - snap_a[1]);
`else
        `CHECK("advance_tied_low", adv_cnt[0] + adv_cnt[1] + adv_cnt[2] + adv_cnt[3], 0)
`endif

        // Lock, then shift stream 3 late by one cycle.
        restart(0, 0, 0, 0);
        wait_sig(0, 600, cyc);
        `CHECK("t5_initial_lock", (cyc > 0), 1'b1)
        base_off[3] = 1;
        wait_sig(1, 200, cyc);
        `CHECK("t5_unlock_seen", (cyc > 0), 1'b1)
        `CHECK("t5_realign_1", realign_count, 16'd1)
        `CHECK("t5_busy_after_exit", busy, 1'b1)
        wait_sig(0, 1000, cyc);
        `CHECK("t5_relock", (cyc > 0), 1'b1)
`ifdef DTS_ALIGN_ADVANCE_EN
        `CHECK("t5_adv3_count", adv_cnt[3] - snap_a[3], 1)
        `CHECK("t5_total_pulses", dsum(), 1)
`else
        `CHECK("t5_delay0_count", dly_cnt[0] - snap_d[0], 1)
        `CHECK("t5_delay3_count", dly_cnt[3] - snap_d[3], 0)
        `CHECK("t5_total_pulses", dsum(), 3)
`endif
        `CHECK("t5_realign_after_relock", realign_count, 16'd1)
        `CHECK("t5_pulse_width", bad_w, 0)
        $display("[TB] relock after shift: realign_count=%0d", realign_count);

        // Shift again and hit reset while the correction pulse is high.
        base_off[3] = 2;
        wait_sig(3, 400, cyc);
        `CHECK("t5_second_pulse", (cyc > 0), 1'b1)
        `CHECK("t5_realign_2", realign_count, 16'd2)
        #2;
        rst_n = 1'b0;
        #1;
        `CHECK("rst_mid_delay", delay, 4'b0000)
        `CHECK("rst_mid_advance", advance, 4'b0000)
        `CHECK("rst_mid_aligned", aligned, 1'b0)
        `CHECK("rst_mid_realign", realign_count, 16'd0)
        $display("[TB] reset mid-pulse: delay=%0d advance=%0d", delay, advance);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
